// File: rtl/shift_reg_universal.sv
// shift_reg_universal: parametrised universal shift register with burst-shift engine.
//
// Per-cycle mode select (hold / shift right / shift left / parallel load) plus an
// autonomous burst engine that shifts a programmed number of positions, one per clock,
// with a busy/done handshake.
//
// Optional feature macro: SHIFT_REG_ROTATE_EN adds the 'rotate' input, which makes every
// shifting edge (mode or burst) recirculate the bit shifted out instead of using ser_in_*.
//
// Ports:
//   clk         rising-edge clock
//   reset_n     asynchronous active-low reset
//   mode        00 hold, 01 shift right, 10 shift left, 11 parallel load
//   d           parallel load data
//   ser_in_msb  bit entering q[WIDTH-1] on a right shift
//   ser_in_lsb  bit entering q[0] on a left shift
//   start       burst request (single-cycle pulse, honoured only when idle)
//   dir         burst direction, sampled with start: 0 right, 1 left
//   shamt       burst shift count, sampled with start, saturates at WIDTH
//   rotate      (SHIFT_REG_ROTATE_EN only) rotate instead of serial fill
//   q           register contents
//   busy        high while the burst engine is not idle
//   done        one-cycle pulse at burst completion
module shift_reg_universal #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] d,
   input  logic             ser_in_msb,
   input  logic             ser_in_lsb,
   input  logic             start,
   input  logic             dir,
   input  logic [CNT_W-1:0] shamt,
`ifdef SHIFT_REG_ROTATE_EN
   input  logic             rotate,
`endif
   output logic [WIDTH-1:0] q,
   output logic             busy,
   output logic             done
);

   localparam logic [1:0] StIdle  = 2'd0;
   localparam logic [1:0] StShift = 2'd1;
   localparam logic [1:0] StDone  = 2'd2;

   localparam logic [1:0] ModeHold  = 2'b00;
   localparam logic [1:0] ModeRight = 2'b01;
   localparam logic [1:0] ModeLeft  = 2'b10;
   localparam logic [1:0] ModeLoad  = 2'b11;

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             dir_q, dir_d;
   logic [WIDTH-1:0] q_q, q_d;

   logic             sin_r, sin_l;
   logic [WIDTH-1:0] shr, shl;
   logic [CNT_W-1:0] shamt_sat;

   // Fill bits for both directions, shared by mode shifts and bursts.
   always_comb begin
`ifdef SHIFT_REG_ROTATE_EN
      sin_r = rotate ? q_q[0]       : ser_in_msb;
      sin_l = rotate ? q_q[WIDTH-1] : ser_in_lsb;
`else
      sin_r = ser_in_msb;
      sin_l = ser_in_lsb;
`endif
      shr = {sin_r, q_q[WIDTH-1:1]};
      shl = {q_q[WIDTH-2:0], sin_l};
   end

   assign shamt_sat = (shamt > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : shamt;

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      dir_d   = dir_q;
      q_d     = q_q;
      case (state_q)
         StIdle: begin
            if (start) begin
               // Start wins over mode; q is left untouched on the accepting edge.
               dir_d = dir;
               if (shamt_sat != '0) begin
                  count_d = shamt_sat;
                  state_d = StShift;
               end else begin
                  state_d = StDone;
               end
            end else begin
               unique case (mode)
                  ModeHold:  q_d = q_q;
                  ModeRight: q_d = shr;
                  ModeLeft:  q_d = shl;
                  ModeLoad:  q_d = d;
                  default:   q_d = q_q;
               endcase
            end
         end
         StShift: begin
            q_d     = dir_q ? shl : shr;
            count_d = count_q - CNT_W'(1);
            if (count_q == CNT_W'(1)) begin
               state_d = StDone;
            end
         end
         StDone: begin
            // mode and start are both ignored on the way back to idle.
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StIdle;
         count_q <= '0;
         dir_q   <= 1'b0;
         q_q     <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         dir_q   <= dir_d;
         q_q     <= q_d;
      end
   end

   assign q    = q_q;
   assign busy = (state_q != StIdle);
   assign done = (state_q == StDone);

endmodule

// File: tb/tb_shift_reg_universal.sv
// Testbench for shift_reg_universal: directed vectors, literal checkpoints, and an
// edge-indexed behavioural model compared against the DUT on every falling clock edge.
module tb_shift_reg_universal;

   localparam int W  = 8;
   localparam int CW = $clog2(W + 1);

   logic          clk = 1'b0;
   logic          reset_n;
   logic [1:0]    mode;
   logic [W-1:0]  d;
   logic          ser_in_msb;
   logic          ser_in_lsb;
   logic          start;
   logic          dir;
   logic [CW-1:0] shamt;
`ifdef SHIFT_REG_ROTATE_EN
   logic          rotate;
`endif
   logic [W-1:0]  q;
   logic          busy;
   logic          done;

   int n_cmp = 0;
   int n_err = 0;
   bit go = 1'b0;

   shift_reg_universal #(
      .WIDTH (W),
      .CNT_W (CW)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .mode       (mode),
      .d          (d),
      .ser_in_msb (ser_in_msb),
      .ser_in_lsb (ser_in_lsb),
      .start      (start),
      .dir        (dir),
      .shamt      (shamt),
`ifdef SHIFT_REG_ROTATE_EN
      .rotate     (rotate),
`endif
      .q          (q),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- Behavioural model ----------------
   // Time is counted in clock edges since reset. A burst accepted at edge bk with
   // length bn shifts on edges bk+1..bk+bn, owns edge bk+bn+1 (DONE->IDLE), is busy
   // after edges bk..bk+bn and signals done after edge bk+bn.
   int           e  = 0;
   int           bk = -10;
   int           bn = 0;
   logic         bdir = 1'b0;
   logic [W-1:0] mq = '0;

   function automatic logic [W-1:0] go_right(input logic [W-1:0] v, input logic s);
      logic [W-1:0] r;
      r = v >> 1;
      r[W-1] = s;
      return r;
   endfunction

   function automatic logic [W-1:0] go_left(input logic [W-1:0] v, input logic s);
      logic [W-1:0] r;
      r = v << 1;
      r[0] = s;
      return r;
   endfunction

   function automatic logic fill_r(input logic [W-1:0] v);
`ifdef SHIFT_REG_ROTATE_EN
      if (rotate) return v[0];
`endif
      return ser_in_msb;
   endfunction

   function automatic logic fill_l(input logic [W-1:0] v);
`ifdef SHIFT_REG_ROTATE_EN
      if (rotate) return v[W-1];
`endif
      return ser_in_lsb;
   endfunction

   initial begin
      forever begin
         @(posedge clk or negedge reset_n);
         if (!reset_n) begin
            e = 0; bk = -10; bn = 0; bdir = 1'b0; mq = '0;
         end else begin
            e = e + 1;
            if (e > bk && e <= bk + bn) begin
               mq = bdir ? go_left(mq, fill_l(mq)) : go_right(mq, fill_r(mq));
            end else if (e == bk + bn + 1) begin
               // returning to idle: nothing applies
            end else if (start) begin
               bk   = e;
               bn   = (int'(shamt) > W) ? W : int'(shamt);
               bdir = dir;
            end else begin
               case (mode)
                  2'b01:   mq = go_right(mq, fill_r(mq));
                  2'b10:   mq = go_left(mq, fill_l(mq));
                  2'b11:   mq = d;
                  default: mq = mq;
               endcase
            end
         end
      end
   end

   // Cycle-by-cycle comparison, away from the active edge.
   initial begin
      wait (go);
      forever begin
         @(negedge clk);
         chk("q_vs_model", q, mq);
         chk("busy_vs_model", busy, (e >= bk && e <= bk + bn));
         chk("done_vs_model", done, (e == bk + bn));
      end
   end

   // ---------------- Directed stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [W-1:0] v);
      mode = 2'b11;
      d    = v;
      tick();
      mode = 2'b00;
   endtask

   initial begin
      reset_n = 1'b0; mode = 2'b00; d = '0; ser_in_msb = 1'b0; ser_in_lsb = 1'b0;
      start = 1'b0; dir = 1'b0; shamt = '0;
`ifdef SHIFT_REG_ROTATE_EN
      rotate = 1'b0;
`endif
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      go = 1'b1;

      // Asynchronous reset from a loaded value.
      load(8'hA5);
      chk("load_a5", q, 32'hA5);
      #2 reset_n = 1'b0;
      #1;
      chk("async_rst_q", q, 32'h00);
      chk("async_rst_busy", busy, 32'h0);
      chk("async_rst_done", done, 32'h0);
      tick();
      reset_n = 1'b1;

      // Load and hold.
      load(8'h3C);
      chk("load_3c", q, 32'h3C);
      repeat (5) tick();
      chk("hold_3c", q, 32'h3C);

      // Mode shifts.
      load(8'h81);
      mode = 2'b01; ser_in_msb = 1'b0; tick();
      chk("shr_40", q, 32'h40);
      mode = 2'b10; ser_in_lsb = 1'b1; tick();
      chk("shl_81", q, 32'h81);
      ser_in_lsb = 1'b0; tick();
      chk("shl_02", q, 32'h02);
      mode = 2'b00;

      // Burst right by 3, mode=11 toggled during the burst.
      load(8'hF0);
      start = 1'b1; dir = 1'b0; shamt = CW'(3); ser_in_msb = 1'b1;
      tick();
      chk("burst_accept_q", q, 32'hF0);
      chk("burst_accept_busy", busy, 32'h1);
      start = 1'b0; mode = 2'b11; d = 8'h00;
      tick(); chk("burst_s1", q, 32'hF8);
      mode = 2'b00; tick(); chk("burst_s2", q, 32'hFC);
      mode = 2'b11; tick(); chk("burst_s3", q, 32'hFE);
      chk("burst_done", done, 32'h1);
      tick();
      chk("burst_end_q", q, 32'hFE);
      chk("burst_end_busy", busy, 32'h0);
      mode = 2'b00;

      // shamt = 0.
      start = 1'b1; shamt = '0; tick();
      chk("zero_busy", busy, 32'h1);
      chk("zero_done", done, 32'h1);
      chk("zero_q", q, 32'hFE);
      start = 1'b0; tick();
      chk("zero_idle", busy, 32'h0);

      // shamt = 15 saturates to 8 left shifts; start held high is ignored while busy.
      load(8'hFF);
      start = 1'b1; dir = 1'b1; shamt = CW'(15); ser_in_lsb = 1'b0;
      tick();
      dir = 1'b0; shamt = CW'(1);
      repeat (7) tick();
      chk("sat_7_shifts", q, 32'h80);
      tick();
      chk("sat_q", q, 32'h00);
      chk("sat_done", done, 32'h1);
      tick();
      chk("sat_start_in_done_ignored", busy, 32'h0);
      start = 1'b0;

      // Reset mid-burst.
      load(8'hA5);
      start = 1'b1; dir = 1'b0; shamt = CW'(8); ser_in_msb = 1'b1;
      tick();
      start = 1'b0;
      repeat (2) tick();
      chk("midburst_q", q, 32'hE9);
      #2 reset_n = 1'b0;
      #1;
      chk("midburst_rst_q", q, 32'h00);
      chk("midburst_rst_busy", busy, 32'h0);
      chk("midburst_rst_done", done, 32'h0);
      tick();
      reset_n = 1'b1;
      load(8'h5A);
      chk("post_rst_load", q, 32'h5A);
      chk("post_rst_busy", busy, 32'h0);

`ifdef SHIFT_REG_ROTATE_EN
      // Rotating burst vs. filling burst.
      load(8'h81);
      rotate = 1'b1; start = 1'b1; dir = 1'b1; shamt = CW'(4);
      tick();
      start = 1'b0;
      repeat (4) tick();
      chk("rot_left_4", q, 32'h18);
      tick();
      load(8'h81);
      rotate = 1'b0; ser_in_lsb = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      repeat (4) tick();
      chk("fill_left_4", q, 32'h10);
      tick();
      // Rotating mode shift.
      rotate = 1'b1; ser_in_msb = 1'b0; mode = 2'b01; tick();
      chk("rot_mode_right", q, 32'h08);
      mode = 2'b00; rotate = 1'b0;
`endif

      repeat (3) tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
